// File: rtl/mem_stage_lsu.sv
// MIPS memory-stage load/store unit in front of a word-addressed data cache.
// Halfword ops (LH/LHU/SH) are built only when LSU_HALF_EN is defined; otherwise they decode as illegal.
module mem_stage_lsu #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [3:0]        ex_op,
    input  logic [31:0]       ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [4:0]        ex_rd,
    output logic [ADDR_W-1:0] dCacheAddr,
    output logic              dCacheWriteEn,
    output logic              dCacheReadEn,
    output logic [DATA_W-1:0] rfReadData_p1,
    input  logic [DATA_W-1:0] loadedData,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign_err,
    output logic              illegal_op
);

    localparam logic [3:0] OpNop = 4'd0;
    localparam logic [3:0] OpLw  = 4'd1;
    localparam logic [3:0] OpLb  = 4'd2;
    localparam logic [3:0] OpLbu = 4'd3;
    localparam logic [3:0] OpSw  = 4'd8;
    localparam logic [3:0] OpSb  = 4'd9;
`ifdef LSU_HALF_EN
    localparam logic [3:0] OpLh  = 4'd4;
    localparam logic [3:0] OpLhu = 4'd5;
    localparam logic [3:0] OpSh  = 4'd10;
`endif

    typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   merge_q;
    logic                wb_valid_q;
    logic [4:0]          wb_rd_q;
    logic [DATA_W-1:0]   wb_data_q;
    logic                misalign_q;
    logic                illegal_q;

    logic                is_nop, is_load, is_sw, is_sub_st, signed_ld, size_byte, legal;
`ifdef LSU_HALF_EN
    logic                size_half;
    logic [15:0]         ld_half;
`endif
    logic                misaligned;
    logic                accept, bad_op, mis_acc, do_access;
    logic [ADDR_W-1:0]   index;
    logic [7:0]          ld_byte;
    logic [DATA_W-1:0]   ld_result;
    logic [DATA_W-1:0]   merged;
    logic                unused_addr;

    // Upper address bits alias onto the cache; they are intentionally dropped.
    assign unused_addr = ^ex_addr[31:ADDR_W+2];
    assign index       = ex_addr[ADDR_W+1:2];

    always_comb begin
        is_nop    = 1'b0;
        is_load   = 1'b0;
        is_sw     = 1'b0;
        is_sub_st = 1'b0;
        signed_ld = 1'b0;
        size_byte = 1'b0;
        legal     = 1'b1;
`ifdef LSU_HALF_EN
        size_half = 1'b0;
`endif
        case (ex_op)
            OpNop: is_nop = 1'b1;
            OpLw:  is_load = 1'b1;
            OpLb: begin
                is_load   = 1'b1;
                size_byte = 1'b1;
                signed_ld = 1'b1;
            end
            OpLbu: begin
                is_load   = 1'b1;
                size_byte = 1'b1;
            end
            OpSw:  is_sw = 1'b1;
            OpSb: begin
                is_sub_st = 1'b1;
                size_byte = 1'b1;
            end
`ifdef LSU_HALF_EN
            OpLh: begin
                is_load   = 1'b1;
                size_half = 1'b1;
                signed_ld = 1'b1;
            end
            OpLhu: begin
                is_load   = 1'b1;
                size_half = 1'b1;
            end
            OpSh: begin
                is_sub_st = 1'b1;
                size_half = 1'b1;
            end
`endif
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
`ifdef LSU_HALF_EN
        if (size_half) begin
            misaligned = ex_addr[0];
        end else
`endif
        if (!size_byte && (is_load || is_sw)) begin
            misaligned = (ex_addr[1:0] != 2'b00);
        end
    end

    assign ex_ready  = (state_q == StIdle);
    assign accept    = ex_valid && ex_ready;
    assign bad_op    = accept && !legal;
    assign mis_acc   = accept && legal && !is_nop && misaligned;
    assign do_access = accept && legal && !is_nop && !misaligned;

    // Little-endian lane extract and extension of the read word.
    always_comb begin
        case (ex_addr[1:0])
            2'd0:    ld_byte = loadedData[7:0];
            2'd1:    ld_byte = loadedData[15:8];
            2'd2:    ld_byte = loadedData[23:16];
            default: ld_byte = loadedData[31:24];
        endcase
        ld_result = loadedData;
        if (size_byte) begin
            ld_result = {{24{signed_ld & ld_byte[7]}}, ld_byte};
        end
`ifdef LSU_HALF_EN
        ld_half = ex_addr[1] ? loadedData[31:16] : loadedData[15:0];
        if (size_half) begin
            ld_result = {{16{signed_ld & ld_half[15]}}, ld_half};
        end
`endif
    end

    // Sub-word store: replace the addressed lane of the read word.
    always_comb begin
        merged = loadedData;
        if (size_byte) begin
            case (ex_addr[1:0])
                2'd0:    merged[7:0]   = ex_wdata[7:0];
                2'd1:    merged[15:8]  = ex_wdata[7:0];
                2'd2:    merged[23:16] = ex_wdata[7:0];
                default: merged[31:24] = ex_wdata[7:0];
            endcase
        end
`ifdef LSU_HALF_EN
        if (size_half) begin
            if (ex_addr[1]) begin
                merged[31:16] = ex_wdata[15:0];
            end else begin
                merged[15:0] = ex_wdata[15:0];
            end
        end
`endif
    end

    always_comb begin
        state_d       = state_q;
        dCacheAddr    = '0;
        dCacheReadEn  = 1'b0;
        dCacheWriteEn = 1'b0;
        rfReadData_p1 = '0;
        unique case (state_q)
            StIdle: begin
                if (do_access) begin
                    dCacheAddr = index;
                    if (is_load || is_sub_st) begin
                        dCacheReadEn = 1'b1;
                    end
                    if (is_sw) begin
                        dCacheWriteEn = 1'b1;
                        rfReadData_p1 = ex_wdata;
                    end
                    if (is_sub_st) begin
                        state_d = StRmwWr;
                    end
                end
            end
            StRmwWr: begin
                dCacheWriteEn = 1'b1;
                dCacheAddr    = addr_q;
                rfReadData_p1 = merge_q;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            merge_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= do_access && is_load;
            misalign_q <= mis_acc;
            illegal_q  <= bad_op;
            if (do_access && is_load) begin
                wb_rd_q   <= ex_rd;
                wb_data_q <= ld_result;
            end
            if (do_access && is_sub_st) begin
                addr_q  <= index;
                merge_q <= merged;
            end
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign misalign_err = misalign_q;
    assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vector table, reset-in-RMW sequence and
// randomized requests against a word-array reference model. Honours LSU_HALF_EN like the DUT.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic [4:0]  dCacheAddr;
    logic        dCacheWriteEn;
    logic        dCacheReadEn;
    logic [31:0] rfReadData_p1;
    logic [31:0] loadedData;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_err;
    logic        illegal_op;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:31];
    logic [31:0] seed_mem [0:31];
    logic [31:0] ref_mem [0:31];
    logic        init_req;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        rd_en;
        logic        wr_en;
        logic        rmw;
        logic [31:0] wword;
        logic        wbv;
        logic [31:0] wbdata;
        logic        mis;
        logic        ill;
    } vec_t;

    mem_stage_lsu #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_op        (ex_op),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_rd        (ex_rd),
        .dCacheAddr   (dCacheAddr),
        .dCacheWriteEn(dCacheWriteEn),
        .dCacheReadEn (dCacheReadEn),
        .rfReadData_p1(rfReadData_p1),
        .loadedData   (loadedData),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .misalign_err (misalign_err),
        .illegal_op   (illegal_op)
    );

    always #5 clk = ~clk;

    // Behavioural cache: combinational read, write at the clock edge.
    assign loadedData = mem[dCacheAddr];
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 32; i++) mem[i] <= seed_mem[i];
        end else if (dCacheWriteEn) begin
            mem[dCacheAddr] <= rfReadData_p1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] rd,
                                input logic rd_en, input logic wr_en, input logic rmw,
                                input logic [31:0] wword, input logic wbv,
                                input logic [31:0] wbdata, input logic mis, input logic ill);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.rd_en = rd_en; v.wr_en = wr_en; v.rmw = rmw; v.wword = wword;
        v.wbv = wbv; v.wbdata = wbdata; v.mis = mis; v.ill = ill;
        return v;
    endfunction

    // Reference model: expected effects of one accepted request; updates ref_mem for stores.
    task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, output vec_t v);
        int size;
        bit ld, sgn, legal;
        int idx, shift;
        logic [31:0] mask, val, w;
        v = mk(op, addr, wdata, rd, 0, 0, 0, 0, 0, 0, 0, 0);
        if (op == 4'd0) return;
        size = 4; ld = 0; sgn = 0; legal = 1;
        case (op)
            4'd1: ld = 1;
            4'd2: begin ld = 1; size = 1; sgn = 1; end
            4'd3: begin ld = 1; size = 1; end
`ifdef LSU_HALF_EN
            4'd4: begin ld = 1; size = 2; sgn = 1; end
            4'd5: begin ld = 1; size = 2; end
            4'd10: size = 2;
`endif
            4'd8: size = 4;
            4'd9: size = 1;
            default: legal = 0;
        endcase
        if (!legal) begin
            v.ill = 1;
            return;
        end
        if ((addr % size) != 0) begin
            v.mis = 1;
            return;
        end
        idx   = int'((addr / 4) % 32);
        shift = int'(addr % 4) * 8;
        mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (size * 8)) - 32'd1);
        if (ld) begin
            val = (ref_mem[idx] >> shift) & mask;
            if (sgn && val[size*8-1]) val = val | ~mask;
            v.rd_en = 1; v.wbv = 1; v.wbdata = val;
        end else if (size == 4) begin
            v.wr_en = 1; v.wword = wdata;
            ref_mem[idx] = wdata;
        end else begin
            w = (ref_mem[idx] & ~(mask << shift)) | ((wdata & mask) << shift);
            v.rd_en = 1; v.rmw = 1; v.wword = w;
            ref_mem[idx] = w;
        end
    endtask

    // Apply one request starting just after a rising edge; returns just after the last edge.
    task automatic issue(input vec_t v);
        ex_valid = 1'b1; ex_op = v.op; ex_addr = v.addr; ex_wdata = v.wdata; ex_rd = v.rd;
        @(negedge clk);
        chk("ex_ready_idle", {31'd0, ex_ready}, 32'd1);
        chk("read_en", {31'd0, dCacheReadEn}, {31'd0, v.rd_en});
        chk("write_en", {31'd0, dCacheWriteEn}, {31'd0, v.wr_en});
        chk("cache_addr", {27'd0, dCacheAddr}, (v.rd_en || v.wr_en) ? {27'd0, v.addr[6:2]} : 32'd0);
        chk("write_data", rfReadData_p1, v.wr_en ? v.wword : 32'd0);
        @(posedge clk); #1;
        if (v.rmw) begin
            // A competing load during the write cycle must be held off.
            ex_op = 4'd1; ex_addr = {$urandom_range(0, 31), 2'b00}; ex_rd = 5'd7;
        end else begin
            ex_valid = 1'b0;
        end
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, v.wbv});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, v.mis});
        chk("illegal_op", {31'd0, illegal_op}, {31'd0, v.ill});
        if (v.wbv) begin
            chk("wb_data", wb_data, v.wbdata);
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, v.rd});
        end
        if (v.rmw) begin
            @(negedge clk);
            chk("rmw_ready", {31'd0, ex_ready}, 32'd0);
            chk("rmw_write_en", {31'd0, dCacheWriteEn}, 32'd1);
            chk("rmw_read_en", {31'd0, dCacheReadEn}, 32'd0);
            chk("rmw_addr", {27'd0, dCacheAddr}, {27'd0, v.addr[6:2]});
            chk("rmw_data", rfReadData_p1, v.wword);
            @(posedge clk); #1;
            ex_valid = 1'b0;
            chk("rmw_no_wb", {31'd0, wb_valid}, 32'd0);
            chk("rmw_no_mis", {31'd0, misalign_err}, 32'd0);
            chk("rmw_no_ill", {31'd0, illegal_op}, 32'd0);
        end
    endtask

    task automatic idle_cycle();
        ex_valid = 1'b0; ex_op = 4'd8; ex_addr = 32'h0000_0010; ex_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("idle_read_en", {31'd0, dCacheReadEn}, 32'd0);
        chk("idle_write_en", {31'd0, dCacheWriteEn}, 32'd0);
        chk("idle_addr", {27'd0, dCacheAddr}, 32'd0);
        @(posedge clk); #1;
        chk("idle_pulses", {29'd0, wb_valid, misalign_err, illegal_op}, 32'd0);
    endtask

    vec_t tbl[$];
    vec_t v, dummy;

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_op = 4'd0; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
        init_req = 1'b1;
        for (int i = 0; i < 32; i++) begin
            seed_mem[i] = $urandom;
            ref_mem[i]  = seed_mem[i];
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_pulses", {30'd0, misalign_err, illegal_op}, 32'd0);
        chk("rst_cache_en", {30'd0, dCacheReadEn, dCacheWriteEn}, 32'd0);
        chk("rst_ready", {31'd0, ex_ready}, 32'd1);
        rst_n = 1'b1;
        init_req = 1'b0;

        //          op     addr           wdata          rd     rd wr rmw wword         wbv wbdata        mis ill
        tbl.push_back(mk(4'd8, 32'h0000_0008, 32'hDEAD_BEEF, 5'd0, 0, 1, 0, 32'hDEAD_BEEF, 0, 32'h0, 0, 0));
        tbl.push_back(mk(4'd1, 32'h0000_0008, 32'h0,         5'd3, 1, 0, 0, 32'h0, 1, 32'hDEAD_BEEF, 0, 0));
        tbl.push_back(mk(4'd2, 32'h0000_000B, 32'h0,         5'd4, 1, 0, 0, 32'h0, 1, 32'hFFFF_FFDE, 0, 0));
        tbl.push_back(mk(4'd3, 32'h0000_000B, 32'h0,         5'd5, 1, 0, 0, 32'h0, 1, 32'h0000_00DE, 0, 0));
`ifdef LSU_HALF_EN
        tbl.push_back(mk(4'd4, 32'h0000_000A, 32'h0,         5'd6, 1, 0, 0, 32'h0, 1, 32'hFFFF_DEAD, 0, 0));
`else
        tbl.push_back(mk(4'd4, 32'h0000_000A, 32'h0,         5'd6, 0, 0, 0, 32'h0, 0, 32'h0, 0, 1));
`endif
        tbl.push_back(mk(4'd9, 32'h0000_0009, 32'h0000_0012, 5'd0, 1, 0, 1, 32'hDEAD_12EF, 0, 32'h0, 0, 0));
        tbl.push_back(mk(4'd1, 32'h0000_0008, 32'h0,         5'd0, 1, 0, 0, 32'h0, 1, 32'hDEAD_12EF, 0, 0));
        tbl.push_back(mk(4'd1, 32'h0000_0006, 32'h0,         5'd1, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0));
`ifdef LSU_HALF_EN
        tbl.push_back(mk(4'd10, 32'h0000_0005, 32'h1234,     5'd0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0));
        tbl.push_back(mk(4'd5, 32'h0000_0008, 32'h0,         5'd9, 1, 0, 0, 32'h0, 1, 32'h0000_12EF, 0, 0));
`else
        tbl.push_back(mk(4'd10, 32'h0000_0005, 32'h1234,     5'd0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 1));
        tbl.push_back(mk(4'd5, 32'h0000_0008, 32'h0,         5'd9, 0, 0, 0, 32'h0, 0, 32'h0, 0, 1));
`endif
        tbl.push_back(mk(4'd7, 32'h0000_0008, 32'h0,         5'd2, 0, 0, 0, 32'h0, 0, 32'h0, 0, 1));
        tbl.push_back(mk(4'd1, 32'hFFFF_FF88, 32'h0,         5'd8, 1, 0, 0, 32'h0, 1, 32'hDEAD_12EF, 0, 0));
        tbl.push_back(mk(4'd0, 32'h0000_0008, 32'h0,         5'd8, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            model(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].rd, dummy);
            issue(tbl[i]);
        end
        idle_cycle();

        // Reset during the RMW write cycle drops the pending write.
        ex_valid = 1'b1; ex_op = 4'd9; ex_addr = 32'h0000_0015; ex_wdata = 32'h0000_00AB;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstrmw_write_en", {31'd0, dCacheWriteEn}, 32'd0);
        chk("rstrmw_read_en", {31'd0, dCacheReadEn}, 32'd0);
        chk("rstrmw_addr_data", {27'd0, dCacheAddr} | rfReadData_p1, 32'd0);
        chk("rstrmw_wb", {wb_valid, wb_rd, misalign_err, illegal_op}, 32'd0);
        chk("rstrmw_wb_data", wb_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model(4'd1, 32'h0000_0014, 32'h0, 5'd11, v);
        issue(v);

        for (int n = 0; n < 300; n++) begin
            logic [3:0]  op;
            logic [31:0] addr;
            case ($urandom_range(0, 9))
                0: op = 4'd0;
                1: op = 4'd1;
                2: op = 4'd2;
                3: op = 4'd3;
                4: op = 4'd4;
                5: op = 4'd5;
                6: op = 4'd8;
                7: op = 4'd9;
                8: op = 4'd10;
                default: op = 4'($urandom_range(0, 15));
            endcase
            addr = $urandom;
            addr[6:2] = 5'($urandom_range(0, 5));
            if ($urandom_range(0, 2) != 0) addr[1:0] = 2'($urandom_range(0, 1) * 2);
            if ($urandom_range(0, 2) == 0) addr[1:0] = 2'b00;
            model(op, addr, $urandom, 5'($urandom), v);
            v.wdata = v.wdata;
            issue(v);
            if ($urandom_range(0, 7) == 0) idle_cycle();
        end

        for (int i = 0; i < 32; i++) begin
            chk($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
